// File: rtl/sseg_scan_decoder.sv
// Seven-segment scan decoder: monitors a multiplexed AN/SSEG/DP bus,
// settle-filters each anode dwell, decodes the segment pattern to hex and
// reports per-digit captures, frame completion and illegal bus activity.
module sseg_scan_decoder #(
   parameter int unsigned SETTLE_CYCLES = 3,
   parameter int unsigned DIGITS        = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic [6:0]            SSEG,
   input  logic [DIGITS-1:0]     AN,
   input  logic                  DP,
   output logic [4*DIGITS-1:0]   digits,
   output logic [DIGITS-1:0]     dp_flags,
   output logic [DIGITS-1:0]     valid,
   output logic                  cap_pulse,
   output logic [2:0]            cap_index,
   output logic                  frame_done,
   output logic                  error
);

   localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES);

   typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

   state_t              state, state_next;
   logic [DIGITS-1:0]   an_q;
   logic [6:0]          seg_q;
   logic                dp_q;
   logic [7:0]          cnt, cnt_next;
   logic [DIGITS-1:0]   seen, seen_upd;
   logic [3:0]          zeros;
   logic [2:0]          an_idx;
   logic                an_changed, an_onehot, an_multi;
   logic                capture, frame_hit;
   logic                seg_legal;
   logic [3:0]          seg_hex;

   // Register the display bus once; everything downstream uses these copies
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         an_q  <= '1;
         seg_q <= '1;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= AN;
         seg_q <= SSEG;
         dp_q  <= DP;
      end
   end

   // Classify the registered anode value: count low lines, locate the lit digit
   always_comb begin
      zeros  = '0;
      an_idx = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (!an_q[i]) begin
            zeros  = zeros + 4'd1;
            an_idx = 3'(i);
         end
      end
      an_onehot  = (zeros == 4'd1);
      an_multi   = (zeros >= 4'd2);
      // Compare against the value an_q takes on this edge so the count
      // restarts on the same edge that loads a new anode value.
      an_changed = (AN != an_q);
   end

   // Active-low a..g pattern to hex digit
   always_comb begin
      seg_legal = 1'b1;
      seg_hex   = '0;
      case (seg_q)
         7'h01: seg_hex = 4'h0;
         7'h4F: seg_hex = 4'h1;
         7'h12: seg_hex = 4'h2;
         7'h06: seg_hex = 4'h3;
         7'h4C: seg_hex = 4'h4;
         7'h24: seg_hex = 4'h5;
         7'h20: seg_hex = 4'h6;
         7'h0F: seg_hex = 4'h7;
         7'h00: seg_hex = 4'h8;
         7'h04: seg_hex = 4'h9;
         7'h08: seg_hex = 4'hA;
         7'h60: seg_hex = 4'hB;
         7'h31: seg_hex = 4'hC;
         7'h42: seg_hex = 4'hD;
         7'h30: seg_hex = 4'hE;
         7'h38: seg_hex = 4'hF;
         default: seg_legal = 1'b0;
      endcase
   end

   // Dwell tracking: stability count, capture decision and next state
   always_comb begin
      cnt_next   = cnt;
      state_next = state;
      capture    = 1'b0;
      if (an_changed || !an_onehot) begin
         cnt_next = '0;
      end else if (cnt < SETTLE_MAX) begin
         cnt_next = cnt + 8'd1;
      end
      capture = !an_changed && an_onehot && (state != HELD) &&
                (cnt_next == SETTLE_MAX);
      if (an_changed || !an_onehot) begin
         state_next = IDLE;
      end else if (capture) begin
         state_next = HELD;
      end else begin
         case (state)
            HELD:    state_next = HELD;
            default: state_next = SETTLE;
         endcase
      end
   end

   // Frame bookkeeping; a coincident clear suppresses frame completion
   always_comb begin
      seen_upd  = seen | ({{(DIGITS-1){1'b0}}, 1'b1} << an_idx);
      frame_hit = capture && (seen_upd == '1) && !clear;
   end

   // Dwell state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Capture registers, strobes, seen set and sticky error
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         digits     <= '0;
         dp_flags   <= '0;
         valid      <= '0;
         cap_pulse  <= 1'b0;
         cap_index  <= '0;
         frame_done <= 1'b0;
         error      <= 1'b0;
         seen       <= '0;
      end else begin
         cap_pulse  <= capture;
         frame_done <= frame_hit;
         if (capture) begin
            cap_index        <= an_idx;
            dp_flags[an_idx] <= ~dp_q;
            valid[an_idx]    <= seg_legal;
            if (seg_legal) begin
               digits[{an_idx, 2'b00} +: 4] <= seg_hex;
            end
         end
         if (clear || frame_hit) begin
            seen <= '0;
         end else if (capture) begin
            seen <= seen_upd;
         end
         if (clear) begin
            error <= 1'b0;
         end else if ((capture && !seg_legal) || an_multi) begin
            error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Scoreboard bench for sseg_scan_decoder: each dwell that should capture
// pushes its expected capture record; a monitor pops on every cap_pulse.
module tb_sseg_scan_decoder;

   localparam int unsigned S = 3;

   logic        clk = 1'b0;
   logic        reset_n, clear, DP;
   logic [6:0]  SSEG;
   logic [7:0]  AN;
   logic [31:0] digits;
   logic [7:0]  dp_flags, valid;
   logic        cap_pulse, frame_done, error;
   logic [2:0]  cap_index;

   sseg_scan_decoder #(.SETTLE_CYCLES(S), .DIGITS(8)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .SSEG(SSEG), .AN(AN), .DP(DP),
      .digits(digits), .dp_flags(dp_flags), .valid(valid), .cap_pulse(cap_pulse),
      .cap_index(cap_index), .frame_done(frame_done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic [2:0]  idx;
      logic [3:0]  nib;
      logic        dpf;
      logic        vld;
      logic        fd;
   } cap_t;

   cap_t        q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int unsigned cyc = 0;

   logic [31:0] m_digits;
   logic [7:0]  m_dp, m_valid, m_seen;
   logic        m_err;

   logic [6:0] pat [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                            7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_state();
      check("digits", m_digits, digits === m_digits ? m_digits : digits);
   endtask

   task automatic check_outputs();
      check("digits", digits, m_digits);
      check("dp_flags", 32'(dp_flags), 32'(m_dp));
      check("valid", 32'(valid), 32'(m_valid));
      check("error", 32'(error), 32'(m_err));
   endtask

   task automatic model_reset();
      m_digits = '0; m_dp = '0; m_valid = '0; m_seen = '0; m_err = 1'b0;
   endtask

   // Hold one anode value for n cycles; optionally pulse clear on the capture edge
   task automatic dwell(input logic [7:0] an, input logic [6:0] seg, input logic dp,
                        input int unsigned n, input bit clr_at_cap);
      cap_t        e;
      int unsigned zeros = 0;
      int unsigned idx = 0;
      bit          legal = 1'b0;
      logic [3:0]  hv = '0;
      AN = an; SSEG = seg; DP = dp;
      for (int unsigned i = 0; i < 8; i++) begin
         if (!an[i]) begin
            zeros++;
            idx = i;
         end
      end
      for (int unsigned h = 0; h < 16; h++) begin
         if (pat[h] == seg) begin
            legal = 1'b1;
            hv = 4'(h);
         end
      end
      if (zeros >= 2 && n >= 2) m_err = 1'b1;
      if (zeros == 1 && n >= S + 1) begin
         e.cyc = cyc + 1 + S;
         e.idx = 3'(idx);
         if (legal) m_digits[4*idx +: 4] = hv;
         else       m_err = 1'b1;
         e.nib = m_digits[4*idx +: 4];
         e.dpf = ~dp;
         e.vld = legal;
         m_dp[idx]    = ~dp;
         m_valid[idx] = legal;
         m_seen[idx]  = 1'b1;
         e.fd = 1'b0;
         if (clr_at_cap) begin
            m_seen = '0;
            m_err  = 1'b0;
         end else if (m_seen == 8'hFF) begin
            e.fd   = 1'b1;
            m_seen = '0;
         end
         q.push_back(e);
      end
      for (int unsigned j = 0; j < n; j++) begin
         @(negedge clk);
         if (clr_at_cap && j + 1 == S)     clear = 1'b1;
         if (clr_at_cap && j + 1 == S + 1) clear = 1'b0;
      end
      clear = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      dwell(8'hFF, 7'h7F, 1'b1, n, 1'b0);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      m_err  = 1'b0;
      m_seen = '0;
      @(negedge clk);
   endtask

   // Monitor: every strobe must match the oldest expected capture
   always @(negedge clk) begin
      cap_t e;
      if (cap_pulse) begin
         if (q.size() == 0) begin
            check("spurious_cap", 32'(cap_pulse), 32'd0);
         end else begin
            e = q.pop_front();
            check("cap_cycle", cyc, e.cyc);
            check("cap_index", 32'(cap_index), 32'(e.idx));
            check("cap_digit", 32'(digits[4*e.idx +: 4]), 32'(e.nib));
            check("cap_dp", 32'(dp_flags[e.idx]), 32'(e.dpf));
            check("cap_valid", 32'(valid[e.idx]), 32'(e.vld));
            check("frame_done", 32'(frame_done), 32'(e.fd));
         end
      end else if (frame_done) begin
         check("frame_done_stray", 32'(frame_done), 32'd0);
      end
   end

   initial begin
      reset_n = 1'b0; clear = 1'b0; AN = '1; SSEG = '1; DP = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs();
      check("rst_cap_pulse", 32'(cap_pulse), 32'd0);
      check("rst_cap_index", 32'(cap_index), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      reset_n = 1'b1;
      idle(2);

      // Single dwell: digit 0 shows 2, DP dark
      dwell(8'hFE, 7'h12, 1'b1, 5, 1'b0);
      idle(3);
      check_outputs();

      // Full scan 0..7, DP lit on digit 5
      for (int unsigned d = 0; d < 8; d++)
         dwell(~(8'h01 << d), pat[d], (d == 5) ? 1'b0 : 1'b1, 4, 1'b0);
      idle(3);
      check_outputs();
      check("scan_digits", digits, 32'h76543210);
      check("scan_dp", 32'(dp_flags), 32'h20);
      check("scan_valid", 32'(valid), 32'hFF);

      // Short dwells: 2 cycles and exactly SETTLE_CYCLES cycles never capture
      dwell(8'hFB, pat[9], 1'b1, 2, 1'b0);
      idle(3);
      dwell(8'hFB, pat[9], 1'b1, S, 1'b0);
      idle(3);
      check_outputs();

      // Illegal pattern on digit 1, then clear
      dwell(8'hFD, 7'h7E, 1'b1, 5, 1'b0);
      idle(3);
      check_outputs();
      pulse_clear();
      check_outputs();

      // Two anodes low
      dwell(8'hFC, pat[3], 1'b1, 10, 1'b0);
      idle(3);
      check_outputs();
      pulse_clear();
      check_outputs();

      // Clear coinciding with the frame-completing capture
      for (int unsigned d = 0; d < 7; d++)
         dwell(~(8'h01 << d), pat[8 + d], 1'b1, 4, 1'b0);
      dwell(8'h7F, pat[15], 1'b0, S + 3, 1'b1);
      idle(3);
      check_outputs();

      // Reset mid-frame after 5 captures, partway into a sixth dwell
      for (int unsigned d = 0; d < 5; d++)
         dwell(~(8'h01 << d), pat[d + 1], 1'b1, 4, 1'b0);
      dwell(8'hDF, pat[6], 1'b1, 2, 1'b0);
      check("pre_reset_queue", q.size(), 32'd0);
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      AN = '1;
      check_outputs();
      reset_n = 1'b1;
      idle(2);
      dwell(8'hFB, pat[12], 1'b1, 4, 1'b0);
      dwell(8'hDF, pat[13], 1'b0, 4, 1'b0);
      dwell(8'h7F, pat[14], 1'b1, 4, 1'b0);
      idle(3);
      check_outputs();

      for (int unsigned t = 0; t < 20 && q.size() != 0; t++) @(negedge clk);
      check("drain", q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sseg_scan_decoder.md
Name: sseg_scan_decoder

Overview:
- Receiving end of the multiplexed seven-segment interface: watches a scanned AN/SSEG/DP bus and reconstructs the 8 displayed hex digits and decimal points.
- Used as an on-chip readback/monitor of the display driver path, feeding a checker or an ILA.
- Performs settle-filtering per dwell, pattern-to-hex decoding, illegal-pattern detection and frame-completion signalling.

Parameters:
- SETTLE_CYCLES, 3: consecutive cycles a one-hot AN value must be held before its segments are captured (range 1..255).
- DIGITS, 8: number of anode positions. Fixed at 8 for this revision.

Ports:
- clk  input  1  system clock (100 MHz)
- reset_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous; clears error and the frame-seen set (digits are kept)
- SSEG  input  7  segment lines, active-low, SSEG[6]=a … SSEG[0]=g
- AN  input  8  anode lines, active-low, one-hot-low when a digit is lit
- DP  input  1  decimal point, active-low
- digits  output  32  digit i held in [4i+3:4i]
- dp_flags  output  8  bit i = 1 if DP was lit on the last capture of digit i
- valid  output  8  bit i = 1 if the last capture of digit i was a legal pattern
- cap_pulse  output  1  one-cycle strobe on each capture
- cap_index  output  3  index of the digit captured (valid with cap_pulse)
- frame_done  output  1  one-cycle strobe when all 8 positions have been captured since the last frame_done/clear
- error  output  1  sticky: illegal pattern or multi-hot AN seen

Behaviour:
- Reset (async, reset_n=0): digits=0, dp_flags=0, valid=0, cap_pulse=0, cap_index=0, frame_done=0, error=0, seen=0, stability count=0, state=IDLE.
- Input stage: AN, SSEG and DP are registered once (an_q, seg_q, dp_q); all logic below uses the registered values.
- Stability count: reset to 0 when an_q differs from its previous value; otherwise increments, saturating at SETTLE_CYCLES.
- States:
  - IDLE: an_q all ones, or just changed.
  - SETTLE: one-hot, count < SETTLE_CYCLES.
  - HELD: captured; waiting for AN to change. At most one capture per dwell.
- Capture: in SETTLE, on the edge where count reaches SETTLE_CYCLES with an_q one-hot:
  - Update digit i, dp_flags[i] = ~dp_q, and valid[i].
  - cap_pulse=1 and cap_index=i for the following cycle.
  - State goes to HELD.
- Latency: with inputs stable from before edge k and SETTLE_CYCLES=3, the capture registers update at edge k+3.
- Decode (seg_q as hex, active-low, order a..g):
  - 01→0, 4F→1, 12→2, 06→3, 4C→4, 24→5, 20→6, 0F→7, 00→8, 04→9, 08→A, 60→b, 31→C, 42→d, 30→E, 38→F.
  - Any other value: digit i unchanged, valid[i]=0, error set. A capture still occurs and still counts toward the frame.
- Multi-hot AN (two or more zeros): no capture, count held at 0, error set.
- All-ones AN: no capture and no error.
- seen[i] is set on each capture of digit i.
- When a capture completes seen=all ones:
  - frame_done pulses on the same cycle as that cap_pulse.
  - seen is cleared on that same edge.
- Repeated capture of an already-seen index: digit updated; seen unchanged.
- clear: error=0 and seen=0 on the next edge. If clear coincides with a capture, the capture is applied first and seen is then cleared, so frame_done is suppressed.
- AN change mid-settle: count restarts and nothing is captured.
- Reset mid-dwell: all state returns to reset values; a stable AN after reset needs a full SETTLE_CYCLES before capture.

Test Plan:
- Reset, then AN=8'hFE, SSEG=7'h12, DP=1 held for 5 cycles → exactly one cap_pulse 3 cycles after the first sampled edge; cap_index=0, digits[3:0]=2, valid[0]=1, dp_flags[0]=0.
- Scan all 8 digits showing 0..7, DP lit on digit 5, 4 cycles each → 8 cap_pulses; frame_done coincides with the 8th; digits=32'h76543210, dp_flags=8'h20, valid=8'hFF.
- AN=8'hFB held for only 2 cycles, then 8'hFF → no cap_pulse and no change to any output.
- AN=8'hFD, SSEG=7'h7E (illegal) → cap_pulse with cap_index=1, valid[1]=0, digits[7:4] unchanged, error=1. Then clear pulse → error=0.
- AN=8'hFC (two low) for 10 cycles → no capture, error=1.
- Assert reset_n=0 mid-frame after 5 captures, release, then scan 3 digits → no frame_done; all outputs at reset values except the 3 newly captured digits.
